// File: rtl/fft16_pkg.sv
// Shared constants and types for the FFT16 result path.
package fft16_pkg;

  localparam int FFT_N      = 16;
  localparam int FFT_WORD_W = 64;

  // Shifter occupancy for the parallel-to-serial stage.
  typedef enum logic {PS_EMPTY, PS_SHIFT} piso_state_t;

endpackage

// File: rtl/piso_stream.sv
// Parallel-in serial-out converter with a one-frame holding buffer so the
// next frame can be captured while the current one shifts out, giving a
// gap-free serial stream. Outputs come from registers through gating only.
// WORD_W must be >= 1 and N_WORDS must be >= 2.
module piso_stream
  import fft16_pkg::*;
#(
  parameter int WORD_W    = FFT_WORD_W,
  parameter int N_WORDS   = FFT_N,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_WORDS*WORD_W-1:0]     in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WORD_W-1:0]             out_data,
  output logic                          out_last,
  output logic [$clog2(N_WORDS)-1:0]    out_index,
  output logic                          busy
);

  localparam int FRAME_W = N_WORDS * WORD_W;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  piso_state_t          state_q, state_d;
  logic [FRAME_W-1:0]   hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 handshake;
  logic                 load;
  logic [WORD_W-1:0]    head_word;

  // in_ready comes straight from the registered full flag, so an accept
  // into hold and a hold->shifter transfer can never share an edge.
  assign in_ready  = !hold_full_q;
  assign out_valid = (state_q == PS_SHIFT);
  assign handshake = out_valid && out_ready;
  assign busy      = (state_q == PS_SHIFT) || hold_full_q;

  // The output word sits at the end of shreg that the shift moves toward.
  assign head_word = LSB_FIRST ? shreg_q[WORD_W-1:0]
                               : shreg_q[FRAME_W-1 -: WORD_W];
  assign out_data  = out_valid ? head_word : '0;
  assign out_last  = out_valid && (cnt_q == LAST_IDX);
  assign out_index = cnt_q;

  // Next-state: shifter FSM, reload from hold, and input capture.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    load        = 1'b0;

    case (state_q)
      PS_EMPTY: begin
        if (hold_full_q) load = 1'b1;
      end
      PS_SHIFT: begin
        if (handshake) begin
          if (cnt_q != LAST_IDX) begin
            shreg_d = LSB_FIRST ? (shreg_q >> WORD_W) : (shreg_q << WORD_W);
            cnt_d   = cnt_q + IDX_W'(1);
          end else if (hold_full_q) begin
            // Chain straight into the buffered frame: no bubble.
            load = 1'b1;
          end else begin
            state_d = PS_EMPTY;
            cnt_d   = '0;   // out_index reads 0 while idle
          end
        end
      end
      default: state_d = PS_EMPTY;
    endcase

    if (load) begin
      shreg_d     = hold_q;
      cnt_d       = '0;
      hold_full_d = 1'b0;
      state_d     = PS_SHIFT;
    end

    if (in_valid && in_ready) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PS_EMPTY;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in serial-out converter with ready/valid handshakes on both sides. It accepts one frame of N_WORDS words of WORD_W bits in a single cycle and emits the words one per cycle, in a selectable order, with a last-word flag. A one-frame holding buffer lets the next frame load while the current one shifts, so the serial stream has no gaps. It sits between the parallel FFT16 butterfly output and the serial result stream.

## Interface
- WORD_W, 64: bits per serial word; must be ≥ 1.
- N_WORDS, 16: words per frame; must be ≥ 2.
- LSB_FIRST, 0: 0 = word 0 is in_data[N_WORDS*WORD_W-1 -: WORD_W] (MSB-first); 1 = word 0 is in_data[WORD_W-1:0].
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a frame.
- in_ready  out  1  holding buffer empty; registered.
- in_data  in  N_WORDS*WORD_W  parallel frame.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  WORD_W  current serial word; 0 when out_valid=0.
- out_last  out  1  current word is index N_WORDS-1; 0 when out_valid=0.
- out_index  out  $clog2(N_WORDS)  index of the current word within the frame; 0 when idle.
- busy  out  1  shifter active or holding buffer full.

## Operation
- Reset (sync, rst=1 at an edge) clears the holding buffer, the shift register, the count and all flags.
  - After reset: in_ready=1, out_valid=0, out_data=0, out_last=0, out_index=0, busy=0.
  - A frame in flight when reset is asserted is discarded.
- Holding buffer (hold, hold_full):
  - in_ready = !hold_full.
  - Accept happens when in_valid && in_ready. At that edge, hold ← in_data and hold_full ← 1.
- Shifter state machine (shreg, cnt, and state EMPTY or SHIFT):
  - EMPTY & hold_full → load: shreg ← hold, cnt ← 0, hold_full ← 0, go to SHIFT.
  - SHIFT, handshake (out_valid && out_ready), cnt < N_WORDS-1 → shift shreg by WORD_W toward the output end, zero-filled; cnt++.
  - SHIFT, handshake, cnt = N_WORDS-1, hold_full → load the next frame from hold in the same edge. Stay in SHIFT. out_valid does not drop.
  - SHIFT, handshake, cnt = N_WORDS-1, !hold_full → go to EMPTY.
  - SHIFT, no handshake → hold all state. out_data stays stable while out_valid && !out_ready.
- Output decoding:
  - out_valid = (state==SHIFT).
  - out_data = top word of shreg (LSB_FIRST=0) or bottom word of shreg (LSB_FIRST=1), gated to 0 when idle.
  - out_last = out_valid && cnt==N_WORDS-1. out_index = cnt.
- A frame moving from hold into the shifter and a new input accept never occur in the same edge, because in_ready is taken from registered hold_full.
- busy = (state==SHIFT) || hold_full.

## Timing
- Latency: a frame accepted at edge E (idle block) moves to the shifter at E+1. Its first word is valid in the cycle after E+1.
- Throughput: with in_valid held high and out_ready=1, frame k+1's word 0 follows frame k's last word with zero bubbles. Sustained rate is 1 word/cycle.
- in_ready deasserts in the cycle after an accept. It reasserts in the cycle after hold empties.
- All outputs are driven from registers through gating only. There is no combinational path from in_valid, in_data or out_ready to any output.

## Structure
- fft16_pkg holds the shared constants:
  - FFT_N = 16, FFT_WORD_W = 64 (the parameter defaults).
  - typedef enum logic {PS_EMPTY, PS_SHIFT} piso_state_t.
- Single module. The holding register is simple enough to stay inline, so no sub-module is required.

## Test plan
- Reset and single frame, WORD_W=8, N_WORDS=4, LSB_FIRST=0.
  - Stimulus: accept in_data=32'hA1B2C3D4, out_ready=1.
  - Required: out_data A1,B2,C3,D4 on consecutive cycles, starting 2 cycles after the accept; out_last only with D4; then out_valid=0, out_data=0.
- LSB_FIRST=1, same frame.
  - Required: D4,C3,B2,A1; out_index 0,1,2,3.
- Back-to-back frames, in_valid held high with frames 32'h01020304 then 32'h05060708, out_ready=1.
  - Required: 01..08 contiguous with no out_valid gap; in_ready low while hold is full.
- Backpressure: drop out_ready for 3 cycles while B2 is shown.
  - Required: B2 stays stable with out_valid=1 and cnt unchanged; the stream resumes with C3; no word is lost or duplicated.
- Reset mid-frame: assert rst after the second word.
  - Required: next cycle shows all outputs at reset values and in_ready=1; a fresh frame then streams correctly from word 0.
- Default parameters (64×16): random frames with random out_ready.
  - Required: a scoreboard matches every word in order; out_last occurs exactly once per 16 words.
